// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: segment codes,
// conversion FSM states and the double-dabble nibble adjust.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } fsm_state_t;

  // Add 3 to every nibble >= 5 so the following left shift carries into
  // the next decade correctly.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit left off. Non-decimal codes blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Bus between the upstream counter and the FND scan controller, including
// the conversion FSM state for observation.
interface fnd_scan_ctrl_if #(
  parameter int VALUE_W = 14
);
  logic [VALUE_W-1:0]   value;
  logic                 dp_on;
  logic [7:0]           seg;
  logic [3:0]           an;
  logic                 ovf;
  logic                 busy;
  fnd_pkg::fsm_state_t  state;

  modport master (
    output value, dp_on,
    input  seg, an, ovf, busy, state
  );

  modport slave (
    input  value, dp_on,
    output seg, an, ovf, busy, state
  );
endinterface

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one capture cycle, VALUE_W shift
// cycles, one commit cycle. Values above 9999 are clamped and flagged.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int VALUE_W = 14
) (
  input  logic                clk,
  input  logic                reset,
  // Handshake: start is honoured only in IDLE; busy is high from the end of
  // LOAD to the end of COMMIT; done is high for exactly the COMMIT cycle,
  // during which bcd/clamp hold the finished result.
  input  logic                start,
  input  logic [VALUE_W-1:0]  din,
  output logic                busy,
  output logic                done,
  output logic                clamp,
  output logic [VALUE_W-1:0]  captured,
  output logic [BCD_W-1:0]    bcd,
  output fsm_state_t          state
);

  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(9999);

  logic [VALUE_W-1:0] bin;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_adj;

  assign bcd_adj = dabble_adjust(bcd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      clamp    <= 1'b0;
      captured <= '0;
      bcd      <= '0;
      bin      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          captured <= din;
          // captured keeps the raw value so change detection settles even
          // when the displayed value is clamped
          if (din > MAX_VAL) begin
            bin   <= MAX_VAL;
            clamp <= 1'b1;
          end else begin
            bin   <= din;
            clamp <= 1'b0;
          end
          bcd   <= '0;
          cnt   <= CNT_W'(VALUE_W);
          busy  <= 1'b1;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd <= {bcd_adj[BCD_W-2:0], bin[VALUE_W-1]};
          bin <= {bin[VALUE_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND driver: converts the binary count to BCD in the
// background and scans a double-buffered digit register onto the display.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1_000,
  parameter int VALUE_W    = 14,
  parameter int LZ_BLANK   = 1,
  parameter int DP_DIGIT   = 2
) (
  input logic             clk,
  input logic             reset,
  fnd_scan_ctrl_if.slave  bus
);

  localparam int SCAN_P = CLK_HZ / REFRESH_HZ;
  localparam int PRE_W  = (SCAN_P > 1) ? $clog2(SCAN_P) : 1;

  logic [VALUE_W-1:0] captured;
  logic [BCD_W-1:0]   bcd;
  logic               start;
  logic               busy;
  logic               done;
  logic               clamp;
  fsm_state_t         state;

  logic [BCD_W-1:0]   digits;
  logic               ovf;
  logic [PRE_W-1:0]   presc;
  logic [1:0]         idx;
  logic [7:0]         seg;
  logic [3:0]         an;

  logic               tick;
  logic [3:0]         cur_digit;
  logic [NUM_DIGITS-1:0] blank;
  logic [7:0]         seg_next;
  logic [3:0]         an_next;

  assign start = (bus.value != captured);

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (bus.value),
    .busy     (busy),
    .done     (done),
    .clamp    (clamp),
    .captured (captured),
    .bcd      (bcd),
    .state    (state)
  );

  // Display register only changes on a finished conversion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= '0;
      ovf    <= 1'b0;
    end else if (done) begin
      digits <= bcd;
      ovf    <= clamp;
    end
  end

  assign tick = (presc == PRE_W'(SCAN_P - 1));

  always_comb begin
    cur_digit = digits[4*idx +: 4];
    blank     = '0;
    if (LZ_BLANK != 0) begin
      blank[3] = (digits[15:12] == 4'd0);
      blank[2] = blank[3] && (digits[11:8] == 4'd0);
      blank[1] = blank[2] && (digits[7:4] == 4'd0);
    end
    seg_next = blank[idx] ? SEG_BLANK : seg_decode(cur_digit);
    // dp is independent of blanking
    if ((idx == 2'(DP_DIGIT)) && bus.dp_on) seg_next[7] = 1'b0;
    an_next = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      seg   <= SEG_BLANK;
      an    <= 4'b1111;
    end else begin
      if (tick) begin
        presc <= '0;
        seg   <= seg_next;
        an    <= an_next;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign bus.seg   = seg;
  assign bus.an    = an;
  assign bus.ovf   = ovf;
  assign bus.busy  = busy;
  assign bus.state = state;

endmodule
